// File: rtl/game_pkg.sv
// Shared phase codes and link bit positions for the two-board match logic.
package game_pkg;

   typedef logic [2:0] phase_t;

   localparam phase_t IDLE      = 3'd0;
   localparam phase_t READY     = 3'd1;
   localparam phase_t COUNTDOWN = 3'd2;
   localparam phase_t PLAY      = 3'd3;
   localparam phase_t OVER      = 3'd4;

   localparam int unsigned LINK_READY = 0;
   localparam int unsigned LINK_START = 1;

   // Phases in which the second counter and link watchdog are live.
   function automatic logic in_run(input phase_t p);
      return (p == COUNTDOWN) || (p == PLAY);
   endfunction

endpackage

// File: rtl/link_sync.sv
// Two-flop synchronizer for the 2-bit inter-board link.
module link_sync (
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] din,
   output logic [1:0] dout
);

   logic [1:0] meta_q;
   logic [1:0] sync_q;

   always_ff @(posedge clock) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= din;
         sync_q <= meta_q;
      end
   end

   assign dout = sync_q;

endmodule

// File: rtl/match_ctrl.sv
// Two-board match sequencer: ready/start handshake, countdown, timed round and
// game-over hold with a peer-link watchdog.
module match_ctrl
   import game_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC      = 200,
   parameter int unsigned COUNTDOWN_S        = 3,
   parameter int unsigned ROUND_S            = 120,
   parameter int unsigned LINK_TIMEOUT_TICKS = 40
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       tick_5ms,
   input  logic       code_ok,
   input  logic       player_sel,
   input  logic       btn,
   input  logic [1:0] link_in,
   output logic [1:0] link_out,
   output logic [2:0] phase,
   output logic       player,
   output logic [7:0] secs_left,
   output logic       go,
   output logic       time_up,
   output logic       aborted
);

   localparam int unsigned SUB_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int unsigned WD_W  = $clog2(LINK_TIMEOUT_TICKS + 1);

   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TICKS_PER_SEC - 1);
   localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(LINK_TIMEOUT_TICKS - 1);
   localparam logic [7:0]       CD_INIT  = 8'(COUNTDOWN_S);
   localparam logic [7:0]       RS_INIT  = 8'(ROUND_S);

   phase_t           state_q, state_d;
   logic             player_q;
   logic             start_q;
   logic             go_q;
   logic             time_up_q;
   logic             aborted_q;
   logic [7:0]       secs_q;
   logic [SUB_W-1:0] sub_q;
   logic [WD_W-1:0]  wd_q, wd_d;

   logic [1:0] link_sync_out;
   logic       peer_ready;
   logic       peer_start;
   logic       running;
   logic       sec_done;
   logic       last_sec;
   logic       wd_trip;
   logic       abort_now;

   link_sync u_link_sync (
      .clock (clock),
      .reset (reset),
      .din   (link_in),
      .dout  (link_sync_out)
   );

   assign peer_ready = link_sync_out[LINK_READY];
   assign peer_start = link_sync_out[LINK_START];

   assign running   = in_run(state_q);
   assign sec_done  = running && tick_5ms && (sub_q == SUB_LAST);
   assign last_sec  = sec_done && (secs_q == 8'd1);
   assign wd_trip   = running && tick_5ms && !peer_ready && (wd_q == WD_LAST);
   // Round expiry outranks a coincident watchdog trip; in COUNTDOWN the trip wins.
   assign abort_now = wd_trip && !((state_q == PLAY) && last_sec);

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (code_ok) state_d = READY;
         end
         READY: begin
            if (!code_ok) begin
               state_d = IDLE;
            end else if (player_q ? peer_start : (btn && peer_ready)) begin
               state_d = COUNTDOWN;
            end
         end
         COUNTDOWN: begin
            if (wd_trip) begin
               state_d = OVER;
            end else if (last_sec) begin
               state_d = PLAY;
            end
         end
         PLAY: begin
            if (last_sec || wd_trip) state_d = OVER;
         end
         OVER: begin
            if (btn) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      link_out             = '0;
      link_out[LINK_READY] = (state_q == READY) || running;
      link_out[LINK_START] = start_q;
      phase                = state_q;
      player               = player_q;
      secs_left            = secs_q;
      go                   = go_q;
      time_up              = time_up_q;
      aborted              = aborted_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         player_q  <= 1'b0;
         start_q   <= 1'b0;
         go_q      <= 1'b0;
         time_up_q <= 1'b0;
         aborted_q <= 1'b0;
      end else begin
         go_q      <= (state_q == COUNTDOWN) && (state_d == PLAY);
         time_up_q <= (state_q == PLAY) && last_sec;
         aborted_q <= (state_d == OVER) && ((state_q == OVER) ? aborted_q : abort_now);
         if ((state_q == IDLE) && (state_d == READY)) begin
            player_q <= player_sel;
         end
         if ((state_q == READY) && (state_d == COUNTDOWN)) begin
            start_q <= !player_q;
         end else if (!in_run(state_d)) begin
            start_q <= 1'b0;
         end
      end
   end

   always_comb begin
      wd_d = wd_q;
      if (peer_ready) begin
         wd_d = '0;
      end else if (tick_5ms) begin
         wd_d = wd_q + 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         secs_q <= '0;
         sub_q  <= '0;
         wd_q   <= '0;
      end else if ((state_q == READY) && (state_d == COUNTDOWN)) begin
         secs_q <= CD_INIT;
         sub_q  <= '0;
         wd_q   <= '0;
      end else if ((state_q == COUNTDOWN) && (state_d == PLAY)) begin
         secs_q <= RS_INIT;
         sub_q  <= '0;
         wd_q   <= wd_d;
      end else if (in_run(state_d)) begin
         if (tick_5ms) begin
            sub_q <= sec_done ? '0 : sub_q + 1'b1;
         end
         if (sec_done) begin
            secs_q <= secs_q - 8'd1;
         end
         wd_q <= wd_d;
      end else begin
         secs_q <= '0;
         sub_q  <= '0;
         wd_q   <= '0;
      end
   end

endmodule
